// File: rtl/hamming_enc_arbiter.sv
// hamming_enc_arbiter
// Round-robin front end that time-shares one external Hamming generator
// among N_REQ requesters. A granted word is captured, presented to the
// generator for one cycle, the resulting codeword is registered and handed
// downstream together with the requester index. Every captured codeword is
// checked for even overall parity; a violation sets a sticky flag.
module hamming_enc_arbiter #(
  parameter int P_BITS = 3,
  parameter int N_REQ  = 4,
  localparam int IP_WIDTH = (1 << P_BITS) - P_BITS - 1,
  localparam int CW_WIDTH = (1 << P_BITS),
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*IP_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [IP_WIDTH-1:0]       enc_data,
  input  logic [CW_WIDTH-1:0]       enc_cw,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CW_WIDTH-1:0]       out_codeword,
  output logic [ID_W-1:0]           out_id,
  output logic                      parity_err,
  output logic                      busy
);

  // The candidate index needs one spare bit so rr_ptr + k can be folded
  // back into range without overflowing.
  localparam int CAND_W = ID_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // Overall parity of an extended-Hamming codeword; a valid word is even.
  function automatic logic cw_odd_parity(input logic [CW_WIDTH-1:0] cw);
    return ^cw;
  endfunction

  logic [1:0]          state_q,      state_d;
  logic [ID_W-1:0]     rr_ptr_q,     rr_ptr_d;
  logic [IP_WIDTH-1:0] data_q,       data_d;
  logic [ID_W-1:0]     id_q,         id_d;
  logic [CW_WIDTH-1:0] cw_q,         cw_d;
  logic                parity_err_q, parity_err_d;

  logic                grant_found_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic [CAND_W-1:0]   cand_s;
  logic                handshake_s;
  logic [IP_WIDTH-1:0] grant_data_s;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_q} + CAND_W'(k);
      if (cand_s >= CAND_W'(N_REQ)) begin
        cand_s = cand_s - CAND_W'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[ID_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[ID_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot accept toward the granted requester, only while idle.
  always_comb begin
    req_ready    = '0;
    handshake_s  = 1'b0;
    grant_data_s = req_data[int'(grant_idx_s)*IP_WIDTH +: IP_WIDTH];
    if ((state_q == ST_IDLE) && grant_found_s) begin
      req_ready[grant_idx_s] = 1'b1;
      handshake_s            = 1'b1;
    end else begin
      req_ready   = '0;
      handshake_s = 1'b0;
    end
  end

  // Sequencer: capture in IDLE, sample the generator in ENC, present in OUT.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    data_d       = data_q;
    id_d         = id_q;
    cw_d         = cw_q;
    parity_err_d = parity_err_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s) begin
          data_d  = grant_data_s;
          id_d    = grant_idx_s;
          state_d = ST_ENC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENC: begin
        cw_d = enc_cw;
        if (cw_odd_parity(enc_cw)) begin
          parity_err_d = 1'b1;
        end else begin
          parity_err_d = parity_err_q;
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          // Next search starts just after the requester we served.
          if (id_q == ID_W'(N_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = id_q + ID_W'(1);
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      data_q       <= '0;
      id_q         <= '0;
      cw_q         <= '0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      data_q       <= data_d;
      id_q         <= id_d;
      cw_q         <= cw_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Outputs come straight from registers so they are glitch-free.
  assign enc_data     = data_q;
  assign out_valid    = (state_q == ST_OUT);
  assign out_codeword = cw_q;
  assign out_id       = id_q;
  assign parity_err   = parity_err_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Self-checking bench for hamming_enc_arbiter. The bench also plays the
// role of the shared Hamming generator, and keeps a small round-robin model
// (pointer + sticky parity flag) to predict grants and results.
module tb_hamming_enc_arbiter;
  localparam int P_BITS   = 3;
  localparam int N_REQ    = 4;
  localparam int IP_WIDTH = (1 << P_BITS) - P_BITS - 1;
  localparam int CW_WIDTH = (1 << P_BITS);
  localparam int ID_W     = 2;
  localparam int RD_W     = N_REQ * IP_WIDTH;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [RD_W-1:0]     req_data = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [IP_WIDTH-1:0] enc_data;
  logic [CW_WIDTH-1:0] enc_cw;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [CW_WIDTH-1:0] out_codeword;
  logic [ID_W-1:0]     out_id;
  logic                parity_err;
  logic                busy;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  bit exp_perr = 1'b0;
  bit fault_inj = 1'b0;

  always #5 clk = ~clk;

  // Extended Hamming: data in non-power-of-two positions, parity bit at
  // position 2^j covers positions with bit j set, bit 0 = overall parity.
  function automatic logic [CW_WIDTH-1:0] ham_ref(input logic [IP_WIDTH-1:0] d);
    logic [CW_WIDTH-1:0] cw;
    int di;
    logic p;
    cw = '0;
    di = 0;
    for (int pos = 1; pos < CW_WIDTH; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[di];
        di++;
      end
    end
    for (int j = 0; j < P_BITS; j++) begin
      p = 1'b0;
      for (int pos = 1; pos < CW_WIDTH; pos++)
        if (((pos & (1 << j)) != 0) && ((pos & (pos - 1)) != 0)) p = p ^ cw[pos];
      cw[1 << j] = p;
    end
    cw[0] = ^cw[CW_WIDTH-1:1];
    return cw;
  endfunction

  assign enc_cw = fault_inj ? 8'h01 : ham_ref(enc_data);

  hamming_enc_arbiter #(.P_BITS(P_BITS), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .enc_data(enc_data), .enc_cw(enc_cw),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_codeword(out_codeword), .out_id(out_id),
    .parity_err(parity_err), .busy(busy)
  );

  // First valid requester searching from ptr with wrap-around; -1 if none.
  function automatic int exp_grant(input int ptr, input logic [N_REQ-1:0] v);
    for (int k = 0; k < N_REQ; k++)
      if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    fault_inj = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ptr = 0;
    exp_perr = 1'b0;
  endtask

  // One full transaction from an idle DUT; stall = OUT cycles with out_ready low.
  task automatic txn(input string tag, input logic [N_REQ-1:0] vmask, input bit keep_valid,
                     input int stall, input bit fault, output int gid, output int obs_id);
    logic [N_REQ-1:0]    exp_rdy;
    logic [IP_WIDTH-1:0] exp_d;
    logic [CW_WIDTH-1:0] exp_cw;
    obs_id = -1;
    req_valid = vmask;
    out_ready = 1'b0;
    #1;
    gid = exp_grant(exp_ptr, vmask);
    exp_rdy = '0;
    if (gid >= 0) exp_rdy[gid] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s grant: req_ready=%b busy=%b expected %b busy=0", tag, req_ready, busy, exp_rdy);
    end
    if (gid < 0) return;
    exp_d = req_data[gid*IP_WIDTH +: IP_WIDTH];
    exp_cw = fault ? 8'h01 : ham_ref(exp_d);
    if (fault) exp_perr = 1'b1;
    @(posedge clk); #1;
    // ENC cycle
    if (keep_valid) req_data[gid*IP_WIDTH +: IP_WIDTH] = IP_WIDTH'($urandom);
    else req_valid[gid] = 1'b0;
    fault_inj = fault;
    out_ready = (stall == 0);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || req_ready !== '0 || enc_data !== exp_d) begin
      errors++;
      $display("FAIL %s enc: busy=%b out_valid=%b req_ready=%b enc_data=%h expected 1 0 0000 %h",
               tag, busy, out_valid, req_ready, enc_data, exp_d);
    end
    @(posedge clk); #1;
    fault_inj = 1'b0;
    obs_id = int'(out_id);
    // OUT cycles: held stable under backpressure, then completion
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_id !== ID_W'(gid) || out_codeword !== exp_cw ||
          parity_err !== exp_perr || busy !== 1'b1 || req_ready !== '0) begin
        errors++;
        $display("FAIL %s out[%0d]: valid=%b id=%0d cw=%h perr=%b busy=%b rdy=%b expected 1 %0d %h %b 1 0000",
                 tag, s, out_valid, out_id, out_codeword, parity_err, busy, req_ready, gid, exp_cw, exp_perr);
      end
      @(posedge clk); #1;
    end
    exp_ptr = (gid + 1) % N_REQ;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || enc_data !== exp_d || parity_err !== exp_perr) begin
      errors++;
      $display("FAIL %s done: out_valid=%b busy=%b enc_data=%h perr=%b expected 0 0 %h %b",
               tag, out_valid, busy, enc_data, parity_err, exp_d, exp_perr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    #3;
    checks++;
    if (req_ready !== '0 || enc_data !== '0 || out_valid !== 1'b0 || out_codeword !== '0 ||
        out_id !== '0 || parity_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b enc=%h ov=%b cw=%h id=%0d perr=%b busy=%b expected all 0",
               req_ready, enc_data, out_valid, out_codeword, out_id, parity_err, busy);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int gid, oid;
    req_data = RD_W'($urandom);
    req_data[2*IP_WIDTH +: IP_WIDTH] = '0;
    txn("single", 4'b0100, 1'b0, 0, 1'b0, gid, oid);
    checks++;
    if (oid != 2) begin
      errors++;
      $display("FAIL single_id: out_id=%0d expected 2", oid);
    end
  endtask

  task automatic test_exhaustive();
    int gid, oid;
    for (int d = 0; d < 16; d++) begin
      req_data = RD_W'($urandom);
      req_data[0 +: IP_WIDTH] = IP_WIDTH'(d);
      txn("exhaustive", 4'b0001, 1'b0, 0, 1'b0, gid, oid);
    end
  endtask

  task automatic test_fairness();
    int gid, oid;
    apply_reset();
    req_data = RD_W'($urandom);
    for (int k = 0; k < 8; k++) begin
      txn("fairness", 4'b1111, 1'b1, 0, 1'b0, gid, oid);
      checks++;
      if (oid != k % N_REQ) begin
        errors++;
        $display("FAIL fairness_seq[%0d]: out_id=%0d expected %0d", k, oid, k % N_REQ);
      end
    end
  endtask

  task automatic test_backpressure();
    int gid, oid;
    for (int k = 0; k < 3; k++) begin
      req_data = RD_W'($urandom);
      txn("backpressure", 4'b0011 << k, 1'b0, 10, 1'b0, gid, oid);
    end
    req_data = RD_W'($urandom);
    txn("bp_random", N_REQ'($urandom_range(1, 15)), 1'b0, int'($urandom_range(1, 6)), 1'b0, gid, oid);
  endtask

  task automatic test_parity();
    int gid, oid;
    req_data = RD_W'($urandom);
    txn("parity_fault", 4'b1000, 1'b0, 0, 1'b1, gid, oid);
    for (int k = 0; k < 2; k++) begin
      req_data = RD_W'($urandom);
      txn("parity_sticky", N_REQ'($urandom_range(1, 15)), 1'b0, 1, 1'b0, gid, oid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear: parity_err=%b expected 0", parity_err);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_op();
    int gid, oid;
    req_data = RD_W'($urandom);
    txn("pre_abort", 4'b0100, 1'b0, 0, 1'b0, gid, oid);
    req_valid = 4'b0100;
    out_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_out: out_valid=%b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: out_valid=%b busy=%b expected 0 0", out_valid, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ptr = 0;
    exp_perr = 1'b0;
    req_data = RD_W'($urandom);
    txn("post_abort", 4'b1010, 1'b0, 0, 1'b0, gid, oid);
    checks++;
    if (oid != 1) begin
      errors++;
      $display("FAIL post_abort_id: out_id=%0d expected 1", oid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_exhaustive();
    test_fairness();
    test_backpressure();
    test_parity();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
